r_column3_rebuild: RTL and testbench

Reconstructs the third channel column H_col3 = r13·Q_col1 + r23·Q_col2 + r33·Q_col3 from the orthonormal Q columns and the third R-column coefficients. This block is the inverse of the Gram-Schmidt column-3 stage of the QR path. It sits after the QR decomposition in the ZF detector and serves two purposes: a self-check path that regenerates H from Q/R, and a re-encoding stage for channel-tracking updates. It uses the same upstream enable/accept_out and downstream ready_out/accept_in handshake as the other column blocks.

---
 rtl/r_column3_rebuild_pkg.sv | 32 +++
 rtl/r_column3_rebuild_vec4_scale_acc.sv | 38 +++
 rtl/r_column3_rebuild.sv | 115 +++++++++++
 tb/tb_r_column3_rebuild.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/r_column3_rebuild_pkg.sv
// Shared constants, state encoding and lane helpers for the QR column rebuild path.
package qr_pkg;
  localparam int LANE_W = 16;
  localparam int FRAC   = 11;
  localparam int ACC_W  = 22;
  localparam int LANES  = 4;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READY = 2'd3
  } state_t;

  function automatic logic signed [LANE_W-1:0] lane_get(input logic [VEC_W-1:0] vec,
                                                        input int lane);
    lane_get = vec[lane*LANE_W +: LANE_W];
  endfunction

  function automatic logic [LANE_W-1:0] sat_acc(input logic signed [ACC_W-1:0] acc);
    logic [LANE_W-1:0] res;
    if (acc > 22'sd32767) begin
      res = 16'h7FFF;
    end else if (acc < -22'sd32768) begin
      res = 16'h8000;
    end else begin
      res = acc[LANE_W-1:0];
    end
    return res;
  endfunction
endpackage

// File: rtl/r_column3_rebuild_vec4_scale_acc.sv
// Four-lane scale-and-accumulate: acc_i += (vec_i * coef) >>> FRAC, with saturated view.
module vec4_scale_acc
  import qr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [VEC_W-1:0]  vec,
  input  logic [LANE_W-1:0] coef,
  output logic [VEC_W-1:0]  sat_out
);
  logic signed [ACC_W-1:0]    r_acc  [LANES];
  logic signed [2*LANE_W-1:0] w_prod [LANES];
  logic signed [ACC_W-1:0]    w_term [LANES];

  // Full-width product, then an arithmetic shift so the term floors toward -inf.
  always_comb begin
    sat_out = {VEC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = lane_get(vec, i) * $signed(coef);
      w_term[i] = ACC_W'(w_prod[i] >>> FRAC);
      sat_out[i*LANE_W +: LANE_W] = sat_acc(r_acc[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset || clear) begin
        r_acc[i] <= {ACC_W{1'b0}};
      end else if (en) begin
        r_acc[i] <= r_acc[i] + w_term[i];
      end else begin
        r_acc[i] <= r_acc[i];
      end
    end
  end
endmodule

// File: rtl/r_column3_rebuild.sv
// Rebuilds H_col3 = r13*Q1 + r23*Q2 + r33*Q3 from captured Q columns and R coefficients.
module r_column3_rebuild
  import qr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        accept_in,
  output logic        accept_out,
  output logic        ready_out,
  input  logic [63:0] Q_col1,
  input  logic [63:0] Q_col2,
  input  logic [63:0] Q_col3,
  input  logic [15:0] r13,
  input  logic [15:0] r23,
  input  logic [15:0] r33,
  output logic [63:0] H_col3
);
  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_k;
  logic [63:0] r_q1, r_q2, r_q3;
  logic [15:0] r_c1, r_c2, r_c3;
  logic [63:0] w_vec;
  logic [15:0] w_coef;
  logic [63:0] w_sat;
  logic        w_clear;
  logic        w_en;

  assign accept_out = (r_state == ST_IDLE);
  assign w_clear    = (r_state == ST_IDLE) && enable;
  assign w_en       = (r_state == ST_MAC);

  always_comb begin
    w_vec  = 64'h0;
    w_coef = 16'h0;
    case (r_k)
      2'd0:    begin w_vec = r_q1; w_coef = r_c1; end
      2'd1:    begin w_vec = r_q2; w_coef = r_c2; end
      2'd2:    begin w_vec = r_q3; w_coef = r_c3; end
      default: begin w_vec = 64'h0; w_coef = 16'h0; end
    endcase
  end

  vec4_scale_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .en      (w_en),
    .vec     (w_vec),
    .coef    (w_coef),
    .sat_out (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_next = ST_MAC;
        else        w_next = ST_IDLE;
      end
      ST_MAC: begin
        if (r_k == 2'd2) w_next = ST_WRITE;
        else             w_next = ST_MAC;
      end
      ST_WRITE: w_next = ST_READY;
      ST_READY: begin
        if (accept_in) w_next = ST_IDLE;
        else           w_next = ST_READY;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture, term counter and output register; H_col3 survives the return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k       <= 2'd0;
      r_q1      <= 64'h0;
      r_q2      <= 64'h0;
      r_q3      <= 64'h0;
      r_c1      <= 16'h0;
      r_c2      <= 16'h0;
      r_c3      <= 16'h0;
      H_col3    <= 64'h0;
      ready_out <= 1'b0;
    end else begin
      ready_out <= (w_next == ST_READY);
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_q1 <= Q_col1;
            r_q2 <= Q_col2;
            r_q3 <= Q_col3;
            r_c1 <= r13;
            r_c2 <= r23;
            r_c3 <= r33;
            r_k  <= 2'd0;
          end
        end
        ST_MAC:   r_k <= r_k + 2'd1;
        ST_WRITE: H_col3 <= w_sat;
        default:  r_k <= r_k;
      endcase
    end
  end
endmodule

// File: tb/tb_r_column3_rebuild.sv
// Scoreboard bench: driver pushes model results, monitor pops on each ready_out rise.
module tb_r_column3_rebuild;
  logic        clk = 1'b0;
  logic        reset, enable, accept_in;
  logic        accept_out, ready_out;
  logic [63:0] Q_col1, Q_col2, Q_col3, H_col3;
  logic [15:0] r13, r23, r33;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic        ready_d = 1'b0;

  typedef struct packed {
    logic [63:0] q1, q2, q3;
    logic [15:0] c1, c2, c3;
  } stim_t;

  always #5 clk = ~clk;

  r_column3_rebuild dut (
    .clk(clk), .reset(reset), .enable(enable), .accept_in(accept_in),
    .accept_out(accept_out), .ready_out(ready_out),
    .Q_col1(Q_col1), .Q_col2(Q_col2), .Q_col3(Q_col3),
    .r13(r13), .r23(r23), .r33(r33), .H_col3(H_col3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [63:0] q1, input logic [63:0] q2, input logic [63:0] q3,
                               input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] c3);
    stim_t s;
    s.q1 = q1; s.q2 = q2; s.q3 = q3;
    s.c1 = c1; s.c2 = c2; s.c3 = c3;
    return s;
  endfunction

  // floor(p / 2048) with plain integer division
  function automatic longint floor_div(input longint p);
    longint f;
    f = p / 64'sd2048;
    if (p < 64'sd0 && (p % 64'sd2048) != 64'sd0) f = f - 64'sd1;
    return f;
  endfunction

  function automatic logic [63:0] model(input stim_t s);
    logic [63:0] res;
    logic [63:0] qs [3];
    logic [15:0] cs [3];
    logic signed [15:0] qv, cv;
    longint acc;
    qs[0] = s.q1; qs[1] = s.q2; qs[2] = s.q3;
    cs[0] = s.c1; cs[1] = s.c2; cs[2] = s.c3;
    res = 64'h0;
    for (int i = 0; i < 4; i++) begin
      acc = 64'sd0;
      for (int t = 0; t < 3; t++) begin
        qv  = qs[t][16*i +: 16];
        cv  = cs[t];
        acc = acc + floor_div(longint'(qv) * longint'(cv));
      end
      if (acc > 64'sd32767)       acc = 64'sd32767;
      else if (acc < -64'sd32768) acc = -64'sd32768;
      res[16*i +: 16] = acc[15:0];
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (ready_out && !ready_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h required=none", H_col3);
      end else begin
        check("result", H_col3, exp_q.pop_front());
      end
    end
    ready_d <= ready_out;
  end

  task automatic run_job(input stim_t s, input int hold, input bit pulse_en, input bit push);
    int n;
    logic [63:0] h0;
    if (push) exp_q.push_back(model(s));
    @(negedge clk);
    Q_col1 = s.q1; Q_col2 = s.q2; Q_col3 = s.q3;
    r13 = s.c1; r23 = s.c2; r33 = s.c3;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    Q_col1 = {$urandom, $urandom}; Q_col2 = {$urandom, $urandom}; Q_col3 = {$urandom, $urandom};
    r13 = 16'($urandom); r23 = 16'($urandom); r33 = 16'($urandom);
    check("accept_out_busy", 64'(accept_out), 64'd0);
    n = 0;
    while (!ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    check("latency", 64'(n), 64'd4);
    h0 = H_col3;
    for (int i = 0; i < hold; i++) begin
      enable = (pulse_en && i == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("hold_ready", 64'(ready_out), 64'd1);
      check("hold_h", H_col3, h0);
    end
    enable    = 1'b0;
    accept_in = 1'b1;
    @(negedge clk);
    accept_in = 1'b0;
    check("accept_out_idle", 64'(accept_out), 64'd1);
    check("ready_low", 64'(ready_out), 64'd0);
  endtask

  initial begin
    stim_t s_id;
    s_id = mk(64'h0000_0000_0000_0800, 64'h0, 64'h0, 16'h0800, 16'h0000, 16'h0000);
    reset = 1'b1; enable = 1'b0; accept_in = 1'b0;
    Q_col1 = 64'h0; Q_col2 = 64'h0; Q_col3 = 64'h0;
    r13 = 16'h0; r23 = 16'h0; r33 = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_h", H_col3, 64'h0);
    check("reset_ready", 64'(ready_out), 64'd0);
    check("reset_accept_out", 64'(accept_out), 64'd1);
    reset = 1'b0;

    run_job(s_id, 0, 1'b0, 1'b1);
    check("identity_h", H_col3, 64'h0000_0000_0000_0800);

    run_job(mk(64'h0000_0000_0000_0800, 64'h0000_0000_0800_0000, 64'h0000_0800_0000_0000,
               16'h0400, 16'h0400, 16'h0400), 1, 1'b0, 1'b1);
    check("basis_h", H_col3, 64'h0000_0400_0400_0400);

    run_job(mk({4{16'h7FFF}}, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 16'h7FFF, 16'h7FFF),
            0, 1'b0, 1'b1);
    check("sat_pos_h", H_col3, 64'h7FFF_7FFF_7FFF_7FFF);

    run_job(mk({4{16'h7FFF}}, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h8001, 16'h8001, 16'h8001),
            0, 1'b0, 1'b1);
    check("sat_neg_h", H_col3, 64'h8000_8000_8000_8000);

    run_job(mk(64'h0000_0000_0000_FFFF, 64'h0, 64'h0, 16'h0001, 16'h0000, 16'h0000),
            0, 1'b0, 1'b1);
    check("floor_h", H_col3, 64'h0000_0000_0000_FFFF);

    run_job(s_id, 10, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("en_in_ready_ignored", 64'(accept_out), 64'd1);

    // abort a job in its second MAC cycle
    @(negedge clk);
    Q_col1 = s_id.q1; Q_col2 = s_id.q2; Q_col3 = s_id.q3;
    r13 = s_id.c1; r23 = s_id.c2; r33 = s_id.c3;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midmac_idle", 64'(accept_out), 64'd1);
    check("midmac_h", H_col3, 64'h0);
    check("midmac_ready", 64'(ready_out), 64'd0);
    run_job(s_id, 0, 1'b0, 1'b1);
    check("post_reset_identity", H_col3, 64'h0000_0000_0000_0800);

    for (int j = 0; j < 24; j++) begin
      run_job(mk({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 16'($urandom), 16'($urandom), 16'($urandom)),
              int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
